// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, condition codes,
// PSR bit positions and FSM state encoding.
package alu_mc_pkg;

    // Operation codes; 4'hC..4'hF are illegal
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDC = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SUBC = 4'h3;
    localparam logic [3:0] OP_CMP  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_MOV  = 4'h8;
    localparam logic [3:0] OP_LSH  = 4'h9;
    localparam logic [3:0] OP_ASHU = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;

    // Branch condition codes
    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_HI = 4'h4;
    localparam logic [3:0] CC_LS = 4'h5;
    localparam logic [3:0] CC_GT = 4'h6;
    localparam logic [3:0] CC_LE = 4'h7;
    localparam logic [3:0] CC_FS = 4'h8;
    localparam logic [3:0] CC_FC = 4'h9;
    localparam logic [3:0] CC_LO = 4'hA;
    localparam logic [3:0] CC_HS = 4'hB;
    localparam logic [3:0] CC_LT = 4'hC;
    localparam logic [3:0] CC_GE = 4'hD;
    localparam logic [3:0] CC_UC = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    // PSR layout is {N,Z,F,L,C}
    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier. Operands load on start, then exactly WIDTH
// iterations follow, one per cycle. The last iteration is presented
// combinationally on product together with done, so the caller can register
// the final value on the same edge the iteration would have completed.
module alu_mul_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    count_r;
    logic             busy_r;
    logic [WIDTH-1:0] acc_next_s;

    // Partial-product accumulation for the current iteration
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    assign done    = busy_r && (count_r == LAST_CNT);
    assign product = acc_next_s;

    // Operand load on start, one shift-add step per cycle while busy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
            busy_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            count_r  <= count_r + CW'(1);
            if (done) begin
                busy_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops with registered result and PSR,
// branch condition evaluation, and an iterative multiplier that stalls issue.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] dst,
    input  logic [WIDTH-1:0] src,
    input  logic [3:0]       cond,
    output logic             cond_true,
    input  logic             psr_we,
    input  logic [4:0]       psr_in,
    output logic             out_valid,
    output logic             wr_en,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       psr
);

    localparam int SW = $clog2(WIDTH) + 1;

    alu_state_e       state_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             wr_en_r;
    logic [WIDTH-1:0] result_r;
    logic [4:0]       psr_r;

    logic             accept_s;
    logic             mul_start_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_product_s;

    logic [WIDTH-1:0] res_s;
    logic             wr_s;
    logic             flag_set_s;
    logic [4:0]       psr_next_s;
    logic             cin_s;
    logic [WIDTH:0]   add_u_s;
    logic [WIDTH:0]   add_x_s;
    logic [WIDTH:0]   sub_u_s;
    logic [WIDTH:0]   sub_x_s;
    logic [SW-1:0]    amt_s;
    logic [SW:0]      mag_s;
    logic             big_s;
    logic             cond_s;

    assign accept_s    = in_valid && in_ready_r;
    assign mul_start_s = accept_s && (op == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start_s),
        .a       (dst),
        .b       (src),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Arithmetic in both unsigned (carry/borrow) and sign-extended (overflow) form
    always_comb begin
        cin_s = 1'b0;
        if ((op == OP_ADDC) || (op == OP_SUBC)) begin
            cin_s = psr_r[PSR_C];
        end else begin
            cin_s = 1'b0;
        end
        add_u_s = {1'b0, dst} + {1'b0, src} + {{WIDTH{1'b0}}, cin_s};
        add_x_s = {dst[WIDTH-1], dst} + {src[WIDTH-1], src} + {{WIDTH{1'b0}}, cin_s};
        sub_u_s = {1'b0, dst} - {1'b0, src} - {{WIDTH{1'b0}}, cin_s};
        sub_x_s = {dst[WIDTH-1], dst} - {src[WIDTH-1], src} - {{WIDTH{1'b0}}, cin_s};
        // Shift amount is a signed field; magnitude carries one extra bit so
        // the most negative amount does not wrap.
        amt_s = src[SW-1:0];
        if (amt_s[SW-1]) begin
            mag_s = {1'b0, ~amt_s} + {{SW{1'b0}}, 1'b1};
        end else begin
            mag_s = {1'b0, amt_s};
        end
        big_s = (32'(mag_s) >= 32'(WIDTH));
    end

    // Result, write enable and next-flag selection per op
    always_comb begin
        res_s      = {WIDTH{1'b0}};
        wr_s       = 1'b0;
        flag_set_s = 1'b0;
        psr_next_s = psr_r;
        case (op)
            OP_ADD, OP_ADDC: begin
                res_s             = add_u_s[WIDTH-1:0];
                wr_s              = 1'b1;
                flag_set_s        = 1'b1;
                psr_next_s[PSR_C] = add_u_s[WIDTH];
                psr_next_s[PSR_F] = add_x_s[WIDTH] ^ add_x_s[WIDTH-1];
            end
            OP_SUB, OP_SUBC: begin
                res_s             = sub_u_s[WIDTH-1:0];
                wr_s              = 1'b1;
                flag_set_s        = 1'b1;
                psr_next_s[PSR_C] = sub_u_s[WIDTH];
                psr_next_s[PSR_F] = sub_x_s[WIDTH] ^ sub_x_s[WIDTH-1];
            end
            OP_CMP: begin
                flag_set_s        = 1'b1;
                psr_next_s[PSR_Z] = (dst == src);
                psr_next_s[PSR_L] = (dst < src);
                psr_next_s[PSR_N] = ($signed(dst) < $signed(src));
            end
            OP_AND: begin
                res_s = dst & src;
                wr_s  = 1'b1;
            end
            OP_OR: begin
                res_s = dst | src;
                wr_s  = 1'b1;
            end
            OP_XOR: begin
                res_s = dst ^ src;
                wr_s  = 1'b1;
            end
            OP_MOV: begin
                res_s = src;
                wr_s  = 1'b1;
            end
            OP_LSH: begin
                wr_s = 1'b1;
                if (big_s) begin
                    res_s = {WIDTH{1'b0}};
                end else if (amt_s[SW-1]) begin
                    res_s = dst >> mag_s;
                end else begin
                    res_s = dst << mag_s;
                end
            end
            OP_ASHU: begin
                wr_s = 1'b1;
                if (big_s) begin
                    res_s = {WIDTH{dst[WIDTH-1]}};
                end else if (amt_s[SW-1]) begin
                    res_s = $signed(dst) >>> mag_s;
                end else begin
                    res_s = dst << mag_s;
                end
            end
            default: begin
                res_s      = {WIDTH{1'b0}};
                wr_s       = 1'b0;
                flag_set_s = 1'b0;
                psr_next_s = psr_r;
            end
        endcase
    end

    // Branch condition evaluated against the registered flags
    always_comb begin
        cond_s = 1'b0;
        case (cond)
            CC_EQ:   cond_s = psr_r[PSR_Z];
            CC_NE:   cond_s = !psr_r[PSR_Z];
            CC_CS:   cond_s = psr_r[PSR_C];
            CC_CC:   cond_s = !psr_r[PSR_C];
            CC_HI:   cond_s = psr_r[PSR_L];
            CC_LS:   cond_s = !psr_r[PSR_L];
            CC_GT:   cond_s = psr_r[PSR_N];
            CC_LE:   cond_s = !psr_r[PSR_N];
            CC_FS:   cond_s = psr_r[PSR_F];
            CC_FC:   cond_s = !psr_r[PSR_F];
            CC_LO:   cond_s = !psr_r[PSR_L] && !psr_r[PSR_Z];
            CC_HS:   cond_s = psr_r[PSR_L] || psr_r[PSR_Z];
            CC_LT:   cond_s = !psr_r[PSR_N] && !psr_r[PSR_Z];
            CC_GE:   cond_s = psr_r[PSR_N] || psr_r[PSR_Z];
            CC_UC:   cond_s = 1'b1;
            CC_NV:   cond_s = 1'b0;
            default: cond_s = 1'b0;
        endcase
    end

    // Issue FSM, registered result/handshake outputs and PSR update
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            wr_en_r     <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            psr_r       <= 5'b00000;
        end else begin
            out_valid_r <= 1'b0;
            wr_en_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (op == OP_MUL) begin
                            state_r    <= ST_MUL;
                            in_ready_r <= 1'b0;
                        end else begin
                            out_valid_r <= 1'b1;
                            wr_en_r     <= wr_s;
                            result_r    <= res_s;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done_s) begin
                        state_r     <= ST_IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b1;
                        wr_en_r     <= 1'b1;
                        result_r    <= mul_product_s;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b1;
                end
            endcase
            // An explicit PSR load takes priority over op-generated flags
            if (psr_we) begin
                psr_r <= psr_in;
            end else if (accept_s && flag_set_s) begin
                psr_r <= psr_next_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign wr_en     = wr_en_r;
    assign result    = result_r;
    assign psr       = psr_r;
    assign cond_true = cond_s;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=16.
module tb_alu_mc;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] dst;
    logic [15:0] src;
    logic [3:0]  cond;
    logic        cond_true;
    logic        psr_we;
    logic [4:0]  psr_in;
    logic        out_valid;
    logic        wr_en;
    logic [15:0] result;
    logic [4:0]  psr;

    int total_cnt;
    int bad_cnt;

    alu_mc #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dst       (dst),
        .src       (src),
        .cond      (cond),
        .cond_true (cond_true),
        .psr_we    (psr_we),
        .psr_in    (psr_in),
        .out_valid (out_valid),
        .wr_en     (wr_en),
        .result    (result),
        .psr       (psr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] o, input logic [15:0] d, input logic [15:0] s);
        in_valid = 1'b1;
        op       = o;
        dst      = d;
        src      = s;
    endtask

    task automatic run_mul(input string tag, input logic [15:0] d, input logic [15:0] s,
                           input logic [15:0] exp);
        int n;
        present(4'hB, d, s);
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check_val({tag, "_lat"}, n, 17);
        check_val({tag, "_res"}, result, exp);
        check_val({tag, "_wr"}, wr_en, 1);
    endtask

    initial begin
        bit seen;
        total_cnt = 0;
        bad_cnt   = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        op        = 4'h0;
        dst       = 16'h0000;
        src       = 16'h0000;
        cond      = 4'h0;
        psr_we    = 1'b0;
        psr_in    = 5'b00000;
        tick();
        tick();
        check_val("rst_ready", in_ready, 1);
        check_val("rst_ovalid", out_valid, 0);
        check_val("rst_wren", wr_en, 0);
        check_val("rst_result", result, 0);
        check_val("rst_psr", psr, 0);
        reset_n = 1'b1;
        tick();

        // ADD signed overflow
        present(4'h0, 16'h7FFF, 16'h0001);
        tick();
        check_val("add_ovalid", out_valid, 1);
        check_val("add_res", result, 16'h8000);
        check_val("add_wr", wr_en, 1);
        check_val("add_psr", psr, 5'b00100);

        // SUB borrow then back-to-back ADDC consuming it
        present(4'h2, 16'h0000, 16'h0001);
        tick();
        check_val("sub_res", result, 16'hFFFF);
        check_val("sub_psr", psr, 5'b00001);
        present(4'h1, 16'h0001, 16'h0001);
        tick();
        check_val("addc_ovalid", out_valid, 1);
        check_val("addc_res", result, 16'h0003);
        check_val("addc_psr", psr, 5'b00000);

        // CMP and condition evaluation
        present(4'h4, 16'h0005, 16'hFFFF);
        tick();
        in_valid = 1'b0;
        check_val("cmp_ovalid", out_valid, 1);
        check_val("cmp_wr", wr_en, 0);
        check_val("cmp_psr", psr, 5'b00010);
        cond = 4'h4; #1 check_val("cc_hi", cond_true, 1);
        cond = 4'h0; #1 check_val("cc_eq", cond_true, 0);
        cond = 4'h6; #1 check_val("cc_gt", cond_true, 0);
        cond = 4'hA; #1 check_val("cc_lo", cond_true, 0);
        tick();
        check_val("idle_ovalid", out_valid, 0);

        // Shifts, logic ops, MOV issued back-to-back
        present(4'h9, 16'h8001, 16'hFFFF);
        tick();
        check_val("lsh_r1", result, 16'h4000);
        present(4'hA, 16'h8001, 16'hFFFF);
        tick();
        check_val("ashu_r1", result, 16'hC000);
        present(4'h9, 16'h8001, 16'h0010);
        tick();
        check_val("lsh_16", result, 16'h0000);
        present(4'h9, 16'h8001, 16'h0004);
        tick();
        check_val("lsh_l4", result, 16'h0010);
        present(4'hA, 16'h8000, 16'h0010);
        tick();
        check_val("ashu_big", result, 16'hFFFF);
        present(4'h7, 16'hF0F0, 16'hFF00);
        tick();
        check_val("xor_res", result, 16'h0FF0);
        present(4'h8, 16'h1111, 16'hBEEF);
        tick();
        check_val("mov_res", result, 16'hBEEF);
        check_val("mov_psr", psr, 5'b00010);

        // Illegal op
        present(4'hC, 16'h1234, 16'h5678);
        tick();
        in_valid = 1'b0;
        check_val("ill_ovalid", out_valid, 1);
        check_val("ill_wr", wr_en, 0);
        check_val("ill_res", result, 0);
        check_val("ill_psr", psr, 5'b00010);

        // PSR load collides with a flag-setting ADD: load wins
        present(4'h0, 16'h7FFF, 16'h0001);
        psr_we = 1'b1;
        psr_in = 5'b10101;
        tick();
        in_valid = 1'b0;
        psr_we   = 1'b0;
        check_val("psrwe_psr", psr, 5'b10101);
        cond = 4'hD; #1 check_val("cc_ge", cond_true, 1);
        cond = 4'hC; #1 check_val("cc_lt", cond_true, 0);
        cond = 4'hE; #1 check_val("cc_uc", cond_true, 1);
        cond = 4'hF; #1 check_val("cc_nv", cond_true, 0);

        // MUL with stall window; in_valid during MUL must be dropped
        present(4'hB, 16'h0003, 16'h0005);
        tick();
        present(4'h8, 16'h0000, 16'hAAAA);
        seen = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (in_ready || out_valid) seen = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check_val("mul_stall", seen, 0);
        check_val("mul_ovalid", out_valid, 1);
        check_val("mul_res", result, 16'h000F);
        check_val("mul_wr", wr_en, 1);
        check_val("mul_ready", in_ready, 1);
        check_val("mul_psr", psr, 5'b10101);
        tick();
        check_val("mul_noqueue", out_valid, 0);

        run_mul("mul_b", 16'h1234, 16'h0100, 16'h3400);
        run_mul("mul_c", 16'hFFFF, 16'hFFFF, 16'h0001);
        run_mul("mul_z", 16'h0000, 16'h0000, 16'h0000);

        // Reset in the middle of a MUL
        present(4'hB, 16'h0003, 16'h0005);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_val("mrst_ready", in_ready, 1);
        check_val("mrst_psr", psr, 0);
        check_val("mrst_ovalid", out_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check_val("mrst_nopulse", seen, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
